ifid_skid_reg: RTL and testbench

//  Parametrised IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/ifid_skid_reg.sv | 124 ++++++++++++
 tb/tb_ifid_skid_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake on both sides and a
// two-entry skid buffer. if_ready comes straight from a flop, so fetch never
// sees a combinational path from decode's id_ready.
module ifid_skid_reg #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     PC_W      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_instr,
   input  logic [PC_W-1:0] if_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [PC_W-1:0] id_pc,
   output logic [1:0]      occupancy
);

   // The encoding doubles as the full flags: bit 0 is main_full, bit 1 is
   // skid_full. 2'b10 would mean a full skid with an empty main slot.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } occ_state_e;

   occ_state_e      state_q, state_d;
   logic            if_ready_q, if_ready_d;
   logic [XLEN-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0] main_pc_q, main_pc_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0] skid_pc_q, skid_pc_d;

   logic main_full, skid_full;
   logic accept, deliver;

   assign main_full = state_q[0];
   assign skid_full = state_q[1];
   assign accept    = if_valid & if_ready_q;
   assign deliver   = main_full & id_ready;

   // Next-state and next-payload selection; flush overrides every transfer.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_instr_d = if_instr;
                  main_pc_d    = if_pc;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  main_instr_d = if_instr;
                  main_pc_d    = if_pc;
               end else if (accept) begin
                  skid_instr_d = if_instr;
                  skid_pc_d    = if_pc;
                  state_d      = TWO;
               end else if (deliver) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // if_ready is low here, so only the drain path exists.
               if (deliver) begin
                  main_instr_d = skid_instr_q;
                  main_pc_d    = skid_pc_q;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      // Registered ready tracks the state it will be paired with.
      if_ready_d = (state_d != TWO);
   end

   // State, ready and both slots; reset returns to EMPTY with ready high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         if_ready_q   <= 1'b1;
         // NOTE: payload slots are reset too; they are only two words and it keeps X out of simulation.
         main_instr_q <= '0;
         main_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         if_ready_q   <= if_ready_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign if_ready  = if_ready_q;
   assign id_valid  = main_full;
   assign id_instr  = main_full ? main_instr_q : NOP_INSTR;
   assign id_pc     = main_full ? main_pc_q : '0;
   assign occupancy = {1'b0, main_full} + {1'b0, skid_full};

   // The skid slot may only hold data behind a full main slot.
   a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst) !(skid_full && !main_full));

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed and random checks for ifid_skid_reg against hand-computed values
// and a two-entry reference queue.
module tb_ifid_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] IA  = 32'hAAAA_0001;
   localparam logic [31:0] IB  = 32'hBBBB_0002;
   localparam logic [31:0] IC  = 32'hCCCC_0003;

   ifid_skid_reg dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_instr  (id_instr),
      .id_pc     (id_pc),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      if_valid = v;
      if_instr = instr;
      if_pc    = pc;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [1:0] occ, input logic rdy);
      check({tag, ".id_valid"}, 64'(id_valid), 64'(v));
      check({tag, ".id_instr"}, 64'(id_instr), 64'(instr));
      check({tag, ".id_pc"}, 64'(id_pc), 64'(pc));
      check({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
      check({tag, ".if_ready"}, 64'(if_ready), 64'(rdy));
   endtask

   task automatic load_ab();
      id_ready = 1'b0;
      drive(1'b1, IA, 32'h40);
      cyc();
      drive(1'b1, IB, 32'h44);
      cyc();
      drive(1'b0, 32'h0, 32'h0);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] t2_instr [3];
      logic [31:0] q_instr [$];
      logic [31:0] q_pc [$];
      logic [31:0] pc_ctr;
      logic        r_valid, r_ready, r_flush;
      int          sz;

      t2_instr[0] = IA;
      t2_instr[1] = IB;
      t2_instr[2] = IC;

      rst = 1'b1;
      flush = 1'b0;
      id_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #12;
      expect_out("reset", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
      rst = 1'b0;
      cyc();

      // T2: streaming, one instruction per cycle.
      id_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, t2_instr[i], 32'(i * 4));
         cyc();
         expect_out($sformatf("t2_stream%0d", i), 1'b1, t2_instr[i], 32'(i * 4), 2'd1, 1'b1);
      end
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      expect_out("t2_drain", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

      // T3: stall fills the skid, release drains in order.
      id_ready = 1'b0;
      drive(1'b1, IA, 32'h10);
      cyc();
      expect_out("t3_one", 1'b1, IA, 32'h10, 2'd1, 1'b1);
      drive(1'b1, IB, 32'h14);
      cyc();
      expect_out("t3_two", 1'b1, IA, 32'h10, 2'd2, 1'b0);
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      expect_out("t3_hold", 1'b1, IA, 32'h10, 2'd2, 1'b0);
      id_ready = 1'b1;
      cyc();
      expect_out("t3_deliver_a", 1'b1, IB, 32'h14, 2'd1, 1'b1);
      cyc();
      expect_out("t3_deliver_b", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

      // T4: flush with both slots full discards the same-cycle input.
      load_ab();
      expect_out("t4_full", 1'b1, IA, 32'h40, 2'd2, 1'b0);
      flush = 1'b1;
      drive(1'b1, IC, 32'h48);
      cyc();
      expect_out("t4_flushed", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      id_ready = 1'b1;
      cyc();
      expect_out("t4_no_c", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

      // T5: release with input pending; C waits one cycle, order kept.
      load_ab();
      id_ready = 1'b1;
      drive(1'b1, IC, 32'h48);
      cyc();
      expect_out("t5_c_refused", 1'b1, IB, 32'h44, 2'd1, 1'b1);
      cyc();
      expect_out("t5_c_taken", 1'b1, IC, 32'h48, 2'd1, 1'b1);
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      expect_out("t5_empty", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

      // T1: asynchronous reset mid-stream while holding two entries.
      load_ab();
      expect_out("t1_pre", 1'b1, IA, 32'h40, 2'd2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      expect_out("t1_async", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
      #2;
      rst = 1'b0;
      cyc();
      expect_out("t1_after", 1'b0, NOP, 32'h0, 2'd0, 1'b1);

      // T6: random valid/ready/flush against a reference queue.
      pc_ctr = 32'h1000;
      for (int n = 0; n < 10000; n++) begin
         sz = q_instr.size();
         check("t6.occupancy", 64'(occupancy), 64'(sz));
         check("t6.if_ready", 64'(if_ready), 64'(sz != 2));
         check("t6.id_valid", 64'(id_valid), 64'(sz != 0));
         if (sz != 0) begin
            check("t6.id_instr", 64'(id_instr), 64'(q_instr[0]));
            check("t6.id_pc", 64'(id_pc), 64'(q_pc[0]));
         end else begin
            check("t6.id_instr_nop", 64'(id_instr), 64'(NOP));
         end

         r_valid = ($urandom_range(0, 3) != 0);
         r_ready = ($urandom_range(0, 2) != 0);
         r_flush = ($urandom_range(0, 31) == 0);
         flush    = r_flush;
         id_ready = r_ready;
         drive(r_valid, $urandom, pc_ctr);

         if (r_flush) begin
            q_instr.delete();
            q_pc.delete();
         end else begin
            if (sz != 0 && r_ready) begin
               void'(q_instr.pop_front());
               void'(q_pc.pop_front());
            end
            if (r_valid && sz != 2) begin
               q_instr.push_back(if_instr);
               q_pc.push_back(if_pc);
               pc_ctr = pc_ctr + 32'd4;
            end
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
